watch_keyset_ctrl: RTL and testbench
====================================

// Module: watch_keyset_ctrl
// PURPOSE
//  Parametrised successor to the basic keypad-set watch. Keeps HH:MM:SS in
//  24h BCD and multiplexes it onto an 8-position common-cathode 7-seg bank.
//  Adds validated digit-by-digit keypad entry with a blinking cursor, a
//  12h/24h display mode, a PM flag and a 1 Hz tick output.
//  Sits between the keypad scanner (strobed keys) and the seg pins.
// PARAMETERS
//  CLK_HZ      1000  input clock frequency; one second = CLK_HZ cycles
//  SCAN_DIV    1     clk cycles spent on each display position (>=1)
//  BLINK_HALF  250   clk cycles per half-period of the entry cursor blink
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst         in   1  asynchronous, active-low reset
//  set_time    in   1  1 = entry mode, 0 = run mode (level)
//  key_valid   in   1  one-cycle strobe, keypad valid this cycle
//  keypad      in   4  key code: 0-9 digit, 4'hC clear entry, others ignored
//  mode_12h    in   1  1 = show hours as 12h, 0 = 24h (display only)
//  seg_data    out  8  segment pattern {dp,g..a} from seg_decode
//  seg_com     out  8  active-low position select, one bit low at a time
//  pm          out  1  1 when stored hour >= 12 (valid in both modes)
//  sec_tick    out  1  one-cycle pulse per elapsed second in RUN
//  entry_busy  out  1  1 while in ENTRY state
// BEHAVIOUR
//  Reset (rst=0, async): time 00:00:00, state RUN, prescaler 0, scan idx 0,
//   seg_com=8'hFF, seg_data=0, pm=0, sec_tick=0, entry_busy=0.
//  Prescaler 0..CLK_HZ-1; wrap in RUN -> sec_tick=1 that cycle and time +1s.
//   BCD carry s_one 9->0, s_ten 5->0, m_one, m_ten 5->0; 23:59:59 -> 00:00:00.
//  FSM: RUN --set_time=1--> ENTRY (prescaler cleared, time frozen,
//   cursor=0, entry buffer cleared, entry_busy=1).
//   ENTRY --6th accepted digit--> DONE: buffer loaded into time same edge.
//   DONE --set_time=0--> RUN; ENTRY --set_time=0--> RUN, buffer discarded,
//   previous time kept. First tick after any exit is exactly CLK_HZ cycles.
//  Entry digit acceptance (key_valid=1, ENTRY only), cursor order HHMMSS:
//   pos0<=2; pos1<=9, <=3 if pos0==2; pos2<=5; pos3<=9; pos4<=5; pos5<=9.
//   Out-of-range digit ignored, cursor holds. 4'hC: buffer 0, cursor 0.
//   key_valid in RUN/DONE ignored. Entry always in 24h format.
//  set_time rising on a prescaler-wrap cycle: ENTRY wins, no increment.
//  Scan: idx 0..7, advances every SCAN_DIV cycles; seg_com bit (7-idx) low.
//   seg_com and seg_data registered from same idx (1-cycle latency, aligned).
//   idx0..5 = H10,H1,M10,M1,S10,S1; idx6,7 seg_data=0.
//  Display source: RUN = live time; ENTRY = buffer, positions >= cursor blank
//   (0) except cursor position, which shows 8'h08 ('_') during blink-on half;
//   DONE = buffer. Blink counter resets on ENTRY entry (starts on).
//  12h: display hour 0->12, 1..12 same, 13..23 -> h-12; leading H10 shown as
//   digit 0. pm = (hour24>=12), driven in ENTRY from buffer once pos1 entered.
//  Widths: prescaler $clog2(CLK_HZ), blink $clog2(BLINK_HALF), scan 3 bits.
// TESTING
//  1 Reset, run 3*CLK_HZ cycles -> sec_tick 3 pulses, time 00:00:03.
//  2 Load 23:59:59, one tick -> 00:00:00, pm 1->0, 12h display shows 12.
//  3 ENTRY keys 2,4,5,9,0,0 -> '4' ignored, cursor stays 1; then 3..0 -> 23:59:00.
//  4 ENTRY keys 1,2,C,0,7 then set_time=0 -> old time kept, resumes after CLK_HZ.
//  5 time 13:05:00, mode_12h=1 -> idx0..5 show 0,1,0,5,0,0; pm=1.
//  6 rst low mid-entry (cursor=3) -> all outputs reset values same cycle.

Source files
------------

// File: rtl/watch_keyset_ctrl.sv
// HH:MM:SS watch with validated keypad entry, blinking cursor, 12h/24h display
// and 1 Hz tick, multiplexed onto an 8-position common-cathode 7-segment bank.
module watch_keyset_ctrl #(
  parameter int CLK_HZ     = 1000,
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time,
  input  logic       key_valid,
  input  logic [3:0] keypad,
  input  logic       mode_12h,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com,
  output logic       pm,
  output logic       sec_tick,
  output logic       entry_busy
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
  localparam logic [DW-1:0] SCAN_MAX  = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTRY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Digit 0 = H10, 1 = H1, 2 = M10, 3 = M1, 4 = S10, 5 = S1.
  typedef logic [5:0][3:0] digits_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic digits_t inc_time(input digits_t t);
    digits_t r;
    r = t;
    if (r[5] != 4'd9) begin
      r[5] = r[5] + 4'd1;
    end else begin
      r[5] = 4'd0;
      if (r[4] != 4'd5) begin
        r[4] = r[4] + 4'd1;
      end else begin
        r[4] = 4'd0;
        if (r[3] != 4'd9) begin
          r[3] = r[3] + 4'd1;
        end else begin
          r[3] = 4'd0;
          if (r[2] != 4'd5) begin
            r[2] = r[2] + 4'd1;
          end else begin
            r[2] = 4'd0;
            if (r[0] == 4'd2 && r[1] == 4'd3) begin
              r[0] = 4'd0;
              r[1] = 4'd0;
            end else if (r[1] == 4'd9) begin
              r[1] = 4'd0;
              r[0] = r[0] + 4'd1;
            end else begin
              r[1] = r[1] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // 24h BCD hour -> 12h BCD hour {tens, ones}; midnight and noon both show 12.
  function automatic logic [7:0] hour_12h(input logic [3:0] h10, input logic [3:0] h1);
    logic [4:0] hb;
    logic [4:0] dh;
    logic [7:0] res;
    hb = ({1'b0, h10} * 5'd10) + {1'b0, h1};
    if (hb == 5'd0) begin
      dh = 5'd12;
    end else if (hb > 5'd12) begin
      dh = hb - 5'd12;
    end else begin
      dh = hb;
    end
    if (dh >= 5'd10) begin
      res = {4'd1, dh[3:0] - 4'd10};
    end else begin
      res = {4'd0, dh[3:0]};
    end
    return res;
  endfunction

  function automatic logic hour_is_pm(input logic [3:0] h10, input logic [3:0] h1);
    return (h10 >= 4'd2) || ((h10 == 4'd1) && (h1 >= 4'd2));
  endfunction

  function automatic logic [3:0] digit_limit(input logic [2:0] pos, input logic [3:0] first);
    logic [3:0] lim;
    case (pos)
      3'd0:    lim = 4'd2;
      3'd1:    lim = (first == 4'd2) ? 4'd3 : 4'd9;
      3'd2:    lim = 4'd5;
      3'd3:    lim = 4'd9;
      3'd4:    lim = 4'd5;
      3'd5:    lim = 4'd9;
      default: lim = 4'd0;
    endcase
    return lim;
  endfunction

  state_t          state_r, state_nx;
  logic [PW-1:0]   presc_r, presc_nx;
  digits_t         time_r, time_nx;
  digits_t         buf_r, buf_nx;
  digits_t         loaded_s;
  logic [2:0]      cursor_r, cursor_nx;
  logic [BW-1:0]   blink_cnt_r, blink_cnt_nx;
  logic            blink_on_r, blink_on_nx;
  logic            tick_nx;
  logic            digit_ok_s;
  logic            pm_nx;
  logic [DW-1:0]   scan_div_r;
  logic [2:0]      scan_idx_r;
  digits_t         src_s;
  logic [7:0]      hr12_s;
  logic [7:0]      seg_nx;
  logic [7:0]      com_nx;

  // Next-state, timekeeping, entry buffer and blink control.
  always_comb begin
    state_nx     = state_r;
    presc_nx     = presc_r;
    time_nx      = time_r;
    buf_nx       = buf_r;
    cursor_nx    = cursor_r;
    blink_cnt_nx = {BW{1'b0}};
    blink_on_nx  = 1'b1;
    tick_nx      = 1'b0;
    loaded_s     = buf_r;
    digit_ok_s   = (cursor_r < 3'd6) && (keypad <= digit_limit(cursor_r, buf_r[0]));
    case (state_r)
      ST_RUN: begin
        if (set_time) begin
          // Entering entry mode takes priority over a coincident second wrap.
          state_nx  = ST_ENTRY;
          presc_nx  = {PW{1'b0}};
          buf_nx    = '0;
          cursor_nx = 3'd0;
        end else if (presc_r == PRESC_MAX) begin
          presc_nx = {PW{1'b0}};
          tick_nx  = 1'b1;
          time_nx  = inc_time(time_r);
        end else begin
          presc_nx = presc_r + PW'(1);
        end
      end
      ST_ENTRY: begin
        presc_nx = {PW{1'b0}};
        if (blink_cnt_r == BLINK_MAX) begin
          blink_cnt_nx = {BW{1'b0}};
          blink_on_nx  = ~blink_on_r;
        end else begin
          blink_cnt_nx = blink_cnt_r + BW'(1);
          blink_on_nx  = blink_on_r;
        end
        if (!set_time) begin
          state_nx = ST_RUN;
        end else if (key_valid && keypad == 4'hC) begin
          buf_nx    = '0;
          cursor_nx = 3'd0;
        end else if (key_valid && digit_ok_s) begin
          loaded_s[cursor_r] = keypad;
          buf_nx             = loaded_s;
          if (cursor_r == 3'd5) begin
            time_nx   = loaded_s;
            state_nx  = ST_DONE;
            cursor_nx = 3'd6;
          end else begin
            cursor_nx = cursor_r + 3'd1;
          end
        end else begin
          buf_nx = buf_r;
        end
      end
      ST_DONE: begin
        presc_nx = {PW{1'b0}};
        if (!set_time) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: begin
        state_nx = ST_RUN;
        presc_nx = {PW{1'b0}};
      end
    endcase
    // Once the hour is fully keyed in, pm follows the entry buffer.
    if (state_nx == ST_ENTRY && cursor_nx >= 3'd2) begin
      pm_nx = hour_is_pm(buf_nx[0], buf_nx[1]);
    end else begin
      pm_nx = hour_is_pm(time_nx[0], time_nx[1]);
    end
  end

  // Core state registers and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_RUN;
      presc_r     <= {PW{1'b0}};
      time_r      <= '0;
      buf_r       <= '0;
      cursor_r    <= 3'd0;
      blink_cnt_r <= {BW{1'b0}};
      blink_on_r  <= 1'b1;
      pm          <= 1'b0;
      sec_tick    <= 1'b0;
      entry_busy  <= 1'b0;
    end else begin
      state_r     <= state_nx;
      presc_r     <= presc_nx;
      time_r      <= time_nx;
      buf_r       <= buf_nx;
      cursor_r    <= cursor_nx;
      blink_cnt_r <= blink_cnt_nx;
      blink_on_r  <= blink_on_nx;
      pm          <= pm_nx;
      sec_tick    <= tick_nx;
      entry_busy  <= (state_nx == ST_ENTRY);
    end
  end

  // Display source selection; 12h conversion applies to complete times only.
  always_comb begin
    com_nx = ~(8'h80 >> scan_idx_r);
    seg_nx = 8'h00;
    src_s  = (state_r == ST_DONE) ? buf_r : time_r;
    hr12_s = hour_12h(src_s[0], src_s[1]);
    src_s[0] = mode_12h ? hr12_s[7:4] : src_s[0];
    src_s[1] = mode_12h ? hr12_s[3:0] : src_s[1];
    if (state_r == ST_ENTRY) begin
      if (scan_idx_r < cursor_r) begin
        seg_nx = seg_decode(buf_r[scan_idx_r]);
      end else if (scan_idx_r == cursor_r) begin
        seg_nx = blink_on_r ? 8'h08 : 8'h00;
      end else begin
        seg_nx = 8'h00;
      end
    end else if (scan_idx_r < 3'd6) begin
      seg_nx = seg_decode(src_s[scan_idx_r]);
    end else begin
      seg_nx = 8'h00;
    end
  end

  // Scan position counter and registered segment/common drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_div_r <= {DW{1'b0}};
      scan_idx_r <= 3'd0;
      seg_com    <= 8'hFF;
      seg_data   <= 8'h00;
    end else begin
      if (scan_div_r == SCAN_MAX) begin
        scan_div_r <= {DW{1'b0}};
        scan_idx_r <= scan_idx_r + 3'd1;
      end else begin
        scan_div_r <= scan_div_r + DW'(1);
        scan_idx_r <= scan_idx_r;
      end
      seg_com  <= com_nx;
      seg_data <= seg_nx;
    end
  end

endmodule

// File: tb/tb_watch_keyset_ctrl.sv
// Randomised and directed bench for watch_keyset_ctrl against a seconds-of-day
// reference model.
module tb_watch_keyset_ctrl;

  localparam int CLK_HZ     = 40;
  localparam int SCAN_DIV   = 2;
  localparam int BLINK_HALF = 6;
  localparam int M_RUN      = 0;
  localparam int M_ENTRY    = 1;
  localparam int M_DONE     = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_time;
  logic       key_valid;
  logic [3:0] keypad;
  logic       mode_12h;
  logic [7:0] seg_data;
  logic [7:0] seg_com;
  logic       pm;
  logic       sec_tick;
  logic       entry_busy;

  int n_vec = 0;
  int n_bad = 0;
  int tick_cnt = 0;

  int m_state, m_secs, m_phase, m_cur, m_ecyc, m_cyc;
  int m_buf[6];
  bit m_tick;

  always #5 clk = ~clk;

  watch_keyset_ctrl #(
    .CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk), .rst(rst), .set_time(set_time), .key_valid(key_valid),
    .keypad(keypad), .mode_12h(mode_12h), .seg_data(seg_data),
    .seg_com(seg_com), .pm(pm), .sec_tick(sec_tick), .entry_busy(entry_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int shown_hour(input int h, input bit m12);
    if (!m12) return h;
    if (h % 12 == 0) return 12;
    return h % 12;
  endfunction

  function automatic logic [7:0] exp_seg(input int idx, input bit m12);
    int h, mi, s;
    int d[6];
    if (m_state == M_ENTRY) begin
      if (idx < m_cur) return seg_of(m_buf[idx]);
      if (idx == m_cur) return (((m_ecyc / BLINK_HALF) % 2) == 0) ? 8'h08 : 8'h00;
      return 8'h00;
    end
    if (idx >= 6) return 8'h00;
    if (m_state == M_RUN) begin
      h = m_secs / 3600; mi = (m_secs / 60) % 60; s = m_secs % 60;
    end else begin
      h = m_buf[0] * 10 + m_buf[1]; mi = m_buf[2] * 10 + m_buf[3]; s = m_buf[4] * 10 + m_buf[5];
    end
    h = shown_hour(h, m12);
    d = '{h / 10, h % 10, mi / 10, mi % 10, s / 10, s % 10};
    return seg_of(d[idx]);
  endfunction

  function automatic bit exp_pm();
    if (m_state == M_ENTRY && m_cur >= 2) return (m_buf[0] * 10 + m_buf[1]) >= 12;
    return (m_secs / 3600) >= 12;
  endfunction

  function automatic int max_digit();
    case (m_cur)
      0: return 2;
      1: return (m_buf[0] == 2) ? 3 : 9;
      2: return 5;
      3: return 9;
      4: return 5;
      default: return 9;
    endcase
  endfunction

  task automatic model_edge(input bit st, input bit kv, input int kp);
    m_tick = 1'b0;
    if (m_state == M_RUN) begin
      if (st) begin
        m_state = M_ENTRY; m_cur = 0; m_ecyc = 0; m_phase = 0;
        foreach (m_buf[i]) m_buf[i] = 0;
      end else begin
        m_phase++;
        if (m_phase == CLK_HZ) begin
          m_phase = 0; m_secs = (m_secs + 1) % 86400; m_tick = 1'b1;
        end
      end
    end else if (m_state == M_ENTRY) begin
      m_ecyc++;
      if (!st) begin
        m_state = M_RUN; m_phase = 0;
      end else if (kv && kp == 12) begin
        m_cur = 0;
        foreach (m_buf[i]) m_buf[i] = 0;
      end else if (kv && kp <= 9 && kp <= max_digit()) begin
        m_buf[m_cur] = kp;
        m_cur++;
        if (m_cur == 6) begin
          m_secs = (m_buf[0] * 10 + m_buf[1]) * 3600 + (m_buf[2] * 10 + m_buf[3]) * 60
                 + m_buf[4] * 10 + m_buf[5];
          m_state = M_DONE;
        end
      end
    end else begin
      if (!st) begin
        m_state = M_RUN; m_phase = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic step(input bit st, input bit kv, input int kp, input bit m12);
    int idx;
    logic [7:0] e_seg, e_com, one;
    set_time = st; key_valid = kv; keypad = 4'(kp); mode_12h = m12;
    idx = (m_cyc / SCAN_DIV) % 8;
    e_seg = exp_seg(idx, m12);
    one = 8'h01;
    e_com = ~(one << (7 - idx));
    @(posedge clk);
    #1;
    model_edge(st, kv, kp);
    check_val("seg_data", 32'(seg_data), 32'(e_seg));
    check_val("seg_com", 32'(seg_com), 32'(e_com));
    check_val("pm", 32'(pm), 32'(exp_pm()));
    check_val("sec_tick", 32'(sec_tick), 32'(m_tick));
    check_val("entry_busy", 32'(entry_busy), 32'(m_state == M_ENTRY));
    if (sec_tick) tick_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b0; set_time = 1'b0; key_valid = 1'b0; keypad = 4'd0;
    #1;
    check_val("rst_seg_com", 32'(seg_com), 32'hFF);
    check_val("rst_seg_data", 32'(seg_data), 32'h00);
    check_val("rst_pm", 32'(pm), 32'h0);
    check_val("rst_sec_tick", 32'(sec_tick), 32'h0);
    check_val("rst_entry_busy", 32'(entry_busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_state = M_RUN; m_secs = 0; m_phase = 0; m_cur = 0; m_ecyc = 0; m_cyc = 0; m_tick = 1'b0;
    foreach (m_buf[i]) m_buf[i] = 0;
  endtask

  task automatic enter_keys(input int ks[$], input bit m12, input bit leave);
    step(1'b1, 1'b0, 0, m12);
    foreach (ks[i]) begin
      step(1'b1, 1'b1, ks[i], m12);
      step(1'b1, 1'b0, 0, m12);
    end
    if (leave) step(1'b0, 1'b0, 0, m12);
  endtask

  initial begin
    bit st, m12;
    rst = 1'b1; set_time = 1'b0; key_valid = 1'b0; keypad = 4'd0; mode_12h = 1'b0;
    #2;
    do_reset();

    tick_cnt = 0;
    repeat (3 * CLK_HZ) step(1'b0, 1'b0, 0, 1'b0);
    check_val("three_ticks", 32'(tick_cnt), 32'd3);

    enter_keys('{2, 3, 5, 9, 5, 9}, 1'b1, 1'b1);
    repeat (CLK_HZ + 2 * 8 * SCAN_DIV) step(1'b0, 1'b0, 0, 1'b1);

    enter_keys('{2, 4, 5, 9, 3, 5, 9, 0, 0}, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 0, 1'b0);

    enter_keys('{1, 2, 12, 0, 7}, 1'b0, 1'b1);
    tick_cnt = 0;
    repeat (CLK_HZ) step(1'b0, 1'b0, 0, 1'b0);
    check_val("resume_tick", 32'(tick_cnt), 32'd1);

    enter_keys('{1, 3, 0, 5, 0, 0}, 1'b1, 1'b1);
    repeat (2 * 8 * SCAN_DIV) step(1'b0, 1'b0, 0, 1'b1);

    st = 1'b0; m12 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) st = ~st;
      if ($urandom_range(0, 199) == 0) m12 = ~m12;
      step(st, ($urandom_range(0, 3) == 0), $urandom_range(0, 15), m12);
    end

    step(1'b0, 1'b0, 0, 1'b0);
    enter_keys('{1, 2, 3}, 1'b0, 1'b0);
    #2;
    do_reset();
    repeat (20) step(1'b0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
